spart_rx_fifo: RTL and testbench

//   Downstream stage of the SPART receiver. Captures each byte the receiver flags with RDA

---
 rtl/spart_rx_fifo.sv | 170 +++++++++++++++++
 tb/tb_spart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_fifo.sv
// -----------------------------------------------------------------------------
// spart_rx_fifo
//   Receive-side FIFO for the SPART. Every byte the receiver flags with a rising
//   edge on rx_rda is captured into a DEPTH-entry circular buffer, and the
//   receiver is acked one cycle later so it can present the next byte. The
//   processor reads the FIFO head (ioaddr 00) or a status byte (ioaddr 01)
//   over the SPART IO bus; a data read pops the head.
//
//   Optional feature macro: SPART_RX_OVERRUN_EN
//     defined   : a byte dropped because the FIFO is full sets a sticky
//                 overrun flag (status bit 7), cleared by a status read.
//     undefined : no overrun flag; status bit 7 reads 0 and drops are silent.
//
// Parameters
//   DEPTH    FIFO entries, power of two in 2..16
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   rx_data  in   [7:0] receiver byte
//   rx_rda   in   receiver byte-available level (high until acked)
//   rx_ack   out  one-cycle ack pulse, one per rx_rda rising edge
//   iocs     in   chip select
//   iorw     in   1 = read, 0 = write (writes are ignored)
//   ioaddr   in   [1:0] 00 data, 01 status, 1x reserved
//   rd_data  out  [7:0] combinational read data
//   rda      out  FIFO not empty
// -----------------------------------------------------------------------------
module spart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rda,
    output logic       rx_ack,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] rd_data,
    output logic       rda
);

    localparam int             PW        = $clog2(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic [4:0]     CNT_DEPTH = 5'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          rx_ack_q, rx_ack_d;
    logic          rda_q, rda_d;
    logic          ovr_bit_s;

    logic push_try_s;
    logic push_ok_s;
    logic pop_s;
    logic data_sel_s;
    logic stat_sel_s;
    logic empty_s;
    logic full_s;

    // Bus decode, flag derivation and push/pop qualification.
    always_comb begin
        data_sel_s = iocs & iorw & (ioaddr == 2'b00);
        stat_sel_s = iocs & iorw & (ioaddr == 2'b01);
        empty_s    = (count_q == 5'd0);
        full_s     = (count_q == CNT_DEPTH);
        // Rising edge of rx_rda, suppressed while the previous ack is still out.
        push_try_s = rx_rda & ~rda_q & ~rx_ack_q;
        pop_s      = data_sel_s & ~empty_s;
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        push_ok_s  = push_try_s & (~full_s | pop_s);
    end

    // Next-state for pointers, occupancy, ack and edge-detect history.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rx_ack_d = push_try_s;     // acked even when the byte is dropped
        rda_d    = rx_rda;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            rx_ack_q <= 1'b0;
            rda_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rx_ack_q <= rx_ack_d;
            rda_q    <= rda_d;
        end
    end

    // Byte storage; deliberately not reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef SPART_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: a drop wins over a clearing status read in the same cycle.
    always_comb begin
        overrun_d = (overrun_q & ~stat_sel_s) | (push_try_s & ~push_ok_s);
        ovr_bit_s = overrun_q;
    end

    // Overrun flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end
`else
    // Without the overrun feature status bit 7 is tied low.
    always_comb begin
        ovr_bit_s = 1'b0;
    end
`endif

    // Read mux and status outputs.
    always_comb begin
        rd_data = 8'h00;
        if (iocs & iorw) begin
            case (ioaddr)
                2'b00: begin
                    if (!empty_s) begin
                        rd_data = mem_q[rd_ptr_q];
                    end else begin
                        rd_data = 8'h00;
                    end
                end
                2'b01:   rd_data = {ovr_bit_s, full_s, empty_s, count_q};
                default: rd_data = 8'h00;
            endcase
        end else begin
            rd_data = 8'h00;
        end
        rda    = ~empty_s;
        rx_ack = rx_ack_q;
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_spart_rx_fifo
//   Scoreboard bench for spart_rx_fifo. A queue-based reference model tracks
//   the bytes the FIFO should hold; a negedge monitor compares rd_data, rda
//   and rx_ack against it every cycle, while directed and random stimulus
//   drives the receiver handshake and the IO bus.
// -----------------------------------------------------------------------------
module tb_spart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int OP_IDLE  = 0;
    localparam int OP_DATA  = 1;
    localparam int OP_STAT  = 2;
    localparam int OP_OTHER = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rda;
    logic       rx_ack;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rd_data;
    logic       rda;

    int vectors;
    int miscompares;
    bit mon_en;
    int hi_cnt;

    // reference model state
    logic [7:0] model_q[$];
    bit         model_ovr;
    bit         model_prev;
    bit         exp_ack;

    spart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_rda  (rx_rda),
        .rx_ack  (rx_ack),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .rd_data (rd_data),
        .rda     (rda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the sampled inputs.
    always @(posedge clk or negedge rst_n) begin : model
        bit attempt, pop, sread, drop;
        if (!rst_n) begin
            model_q.delete();
            model_ovr  = 1'b0;
            model_prev = 1'b0;
            exp_ack    = 1'b0;
        end else begin
            attempt = rx_rda && !model_prev && !exp_ack;
            pop     = iocs && iorw && (ioaddr == 2'b00) && (model_q.size() > 0);
            sread   = iocs && iorw && (ioaddr == 2'b01);
            drop    = 1'b0;
            if (pop) void'(model_q.pop_front());
            if (attempt) begin
                if (model_q.size() < DEPTH) model_q.push_back(rx_data);
                else drop = 1'b1;
            end
`ifdef SPART_RX_OVERRUN_EN
            model_ovr = (model_ovr && !sread) || drop;
`else
            model_ovr = 1'b0;
`endif
            exp_ack    = attempt;
            model_prev = rx_rda;
        end
    end

    // Monitor: compare DUT outputs against the model away from the clock edge.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        int n;
        if (mon_en) begin
            n = model_q.size();
            e = 8'h00;
            if (iocs && iorw) begin
                if (ioaddr == 2'b00) e = (n > 0) ? model_q[0] : 8'h00;
                else if (ioaddr == 2'b01) e = {model_ovr, n == DEPTH, n == 0, 5'(n)};
            end
            chk("mon_rd_data", rd_data, e);
            chk("mon_rda", {7'd0, rda}, {7'd0, n != 0});
            chk("mon_rx_ack", {7'd0, rx_ack}, {7'd0, exp_ack});
        end
    end

    task automatic set_bus(input int op);
        int k;
        case (op)
            OP_DATA: begin iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; end
            OP_STAT: begin iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01; end
            OP_OTHER: begin
                k = $urandom_range(0, 2);
                if (k == 0)      begin iocs = 1'b0; iorw = 1'b1; ioaddr = 2'($urandom_range(0, 3)); end
                else if (k == 1) begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'($urandom_range(0, 3)); end
                else             begin iocs = 1'b1; iorw = 1'b1; ioaddr = {1'b1, 1'($urandom_range(0, 1))}; end
            end
            default: begin iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; end
        endcase
    endtask

    // One cycle: receiver handshake, bus op, advance to just after the next edge.
    task automatic step(input bit want_push, input logic [7:0] b, input int op);
        if (rx_rda && rx_ack) begin
            rx_rda = 1'b0;
            hi_cnt = 0;
        end else if (rx_rda) begin
            hi_cnt++;
            if (hi_cnt > 3) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timeout: rx_ack missing for %0d cycles", hi_cnt);
                rx_rda = 1'b0;
                hi_cnt = 0;
            end
        end else if (want_push) begin
            rx_rda  = 1'b1;
            rx_data = b;
        end
        set_bus(op);
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        step(1'b1, b, OP_IDLE);
        step(1'b0, 8'h00, OP_IDLE);
    endtask

    task automatic peek(input int op, input string name, input logic [7:0] exp);
        set_bus(op);
        #1;
        chk(name, rd_data, exp);
    endtask

    logic [7:0] exp4 [8];

    initial begin
        int op, r;
        vectors = 0; miscompares = 0; mon_en = 1'b0; hi_cnt = 0;
        rst_n = 1'b0; rx_rda = 1'b0; rx_data = 8'h00;
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // 1: reset state
        chk("rst_rda", {7'd0, rda}, 8'h00);
        chk("rst_ack", {7'd0, rx_ack}, 8'h00);
        peek(OP_STAT, "rst_status", 8'h20);
        peek(OP_DATA, "rst_data", 8'h00);

        // 2: single byte
        step(1'b1, 8'hA5, OP_IDLE);
        chk("t2_ack", {7'd0, rx_ack}, 8'h01);
        chk("t2_rda", {7'd0, rda}, 8'h01);
        peek(OP_STAT, "t2_status", 8'h01);
        peek(OP_DATA, "t2_data", 8'hA5);
        step(1'b0, 8'h00, OP_DATA);
        chk("t2_rda_after", {7'd0, rda}, 8'h00);

        // 3: fill and overflow
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        peek(OP_STAT, "t3_full", 8'h48);
        step(1'b1, 8'h09, OP_IDLE);
        chk("t3_drop_ack", {7'd0, rx_ack}, 8'h01);
`ifdef SPART_RX_OVERRUN_EN
        peek(OP_STAT, "t3_ovr_status", 8'hC8);
`else
        peek(OP_STAT, "t3_ovr_status", 8'h48);
`endif
        step(1'b0, 8'h00, OP_STAT);
        peek(OP_STAT, "t3_status2", 8'h48);

        // 4: push coincident with pop while full
        rx_rda = 1'b1; rx_data = 8'h0F;
        peek(OP_DATA, "t4_head", 8'h01);
        @(posedge clk); #1;
        peek(OP_STAT, "t4_count", 8'h48);
        for (int j = 0; j < 7; j++) exp4[j] = 8'(j + 2);
        exp4[7] = 8'h0F;
        for (int j = 0; j < 8; j++) begin
            peek(OP_DATA, "t4_order", exp4[j]);
            step(1'b0, 8'h00, OP_DATA);
        end
        chk("t4_empty", {7'd0, rda}, 8'h00);

        // 5: interleaved traffic across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            push_byte(8'h40 + 8'(2 * i));
            push_byte(8'h41 + 8'(2 * i));
            step(1'b0, 8'h00, OP_DATA);
            step(1'b0, 8'h00, OP_DATA);
        end
        chk("t5_empty", {7'd0, rda}, 8'h00);

        // random traffic, balanced then push-heavy
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 99);
            if (i < 600) op = (r < 25) ? OP_DATA : (r < 40) ? OP_STAT : (r < 60) ? OP_OTHER : OP_IDLE;
            else         op = (r < 8)  ? OP_DATA : (r < 20) ? OP_STAT : (r < 40) ? OP_OTHER : OP_IDLE;
            step($urandom_range(0, 9) < 7, 8'($urandom), op);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, OP_DATA);

        // 6: reset mid-operation with a push in flight
        for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
        step(1'b1, 8'h77, OP_IDLE);
        rst_n = 1'b0;
        #1;
        chk("t6_rda", {7'd0, rda}, 8'h00);
        chk("t6_ack", {7'd0, rx_ack}, 8'h00);
        rx_rda = 1'b0;
        set_bus(OP_IDLE);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        peek(OP_STAT, "t6_status", 8'h20);
        chk("t6_rda_after", {7'd0, rda}, 8'h00);
        step(1'b0, 8'h00, OP_IDLE);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
